serial_sub_16bits: RTL and testbench

Sequential 16-bit subtractor with a start/done handshake. It computes `in1 - in2 - bin`, processing one `SLICE_W`-bit slice per clock, least-significant slice first, with a ripple borrow carried between slices. It is the subtract-direction counterpart of the team's 16-bit ripple-carry adder wrapper. It uses the same clk/rst and in1/in2/out operand naming and sits beside that adder in the COA lab datapath.

---
 rtl/serial_sub_16bits.sv | 81 ++++++++
 tb/tb_serial_sub_16bits.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_sub_16bits.sv
// serial_sub_16bits: slice-serial 16-bit subtractor (in1 - in2 - bin) with start/done handshake; `SUB_OVERFLOW_EN adds the ovf port
module serial_sub_16bits #(
    parameter int SLICE_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic        bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic        bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic        ovf
`endif
);
    localparam int N = 16 / SLICE_W;
    localparam logic [3:0] K_LAST = 4'(N - 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t           r_state, w_next;
    logic [15:0]      r_a, r_b, r_out;
    logic             r_borrow, r_bout;
    logic [3:0]       r_k;
    logic [3:0]       w_lsb;
    logic [SLICE_W:0] w_diff;
    logic             w_last;
    assign w_lsb  = 4'(int'(r_k) * SLICE_W);
    assign w_diff = {1'b0, r_a[w_lsb +: SLICE_W]} - {1'b0, r_b[w_lsb +: SLICE_W]} - {{SLICE_W{1'b0}}, r_borrow};
    assign w_last = (r_k == K_LAST);
    assign busy   = (r_state == CALC);
    assign done   = (r_state == DONE);
    assign out    = r_out;
    assign bout   = r_bout;
    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    // next state: start is only looked at in IDLE, DONE always falls back to IDLE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? CALC : IDLE;
            CALC:    w_next = w_last ? DONE : CALC;
            default: w_next = IDLE;
        endcase
    end
    // capture operands on acceptance, then one slice per CALC cycle, LSB first
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_out    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_k      <= '0;
        end else if (r_state == IDLE && start) begin
            r_a      <= in1;
            r_b      <= in2;
            r_borrow <= bin;
            r_k      <= '0;
        end else if (r_state == CALC) begin
            r_out[w_lsb +: SLICE_W] <= w_diff[SLICE_W-1:0];
            r_borrow                <= w_diff[SLICE_W];
            r_k                     <= r_k + 4'd1;
            if (w_last) r_bout <= w_diff[SLICE_W];
        end
    end
`ifdef SUB_OVERFLOW_EN
    logic r_ovf;
    assign ovf = r_ovf;
    // overflow from operand signs and the sign bit produced by the final slice
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                       r_ovf <= 1'b0;
        else if (r_state == CALC && w_last) r_ovf <= (r_a[15] ^ r_b[15]) & (w_diff[SLICE_W-1] ^ r_a[15]);
    end
`endif
endmodule

// File: tb/tb_serial_sub_16bits.sv
// tb_serial_sub_16bits: directed checks of serial_sub_16bits with SLICE_W=4 and SLICE_W=1
module tb_serial_sub_16bits;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start4 = 1'b0;
    logic        start1 = 1'b0;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        bin = 1'b0;
    logic        busy4, done4, bout4, busy1, done1, bout1;
    logic [15:0] out4, out1;
    logic        ovf4, ovf1;
    int          checks = 0;
    int          failures = 0;

    serial_sub_16bits #(.SLICE_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .in1(in1), .in2(in2), .bin(bin),
        .busy(busy4), .done(done4), .out(out4), .bout(bout4)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf4)
`endif
    );
    serial_sub_16bits #(.SLICE_W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in1(in1), .in2(in2), .bin(bin),
        .busy(busy1), .done(done1), .out(out1), .bout(bout1)
`ifdef SUB_OVERFLOW_EN
        , .ovf(ovf1)
`endif
    );
`ifndef SUB_OVERFLOW_EN
    assign ovf4 = 1'b0;
    assign ovf1 = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string tag, input bit one, input logic [15:0] a, input logic [15:0] b,
                      input logic c, input int exp_lat, input logic [15:0] exp_out,
                      input logic exp_bout, input logic exp_ovf);
        int lat;
        in1 = a; in2 = b; bin = c;
        if (one) start1 = 1'b1; else start4 = 1'b1;
        tick;
        start1 = 1'b0; start4 = 1'b0;
        check({tag, "_busy_at_accept"}, one ? busy1 : busy4, 1);
        check({tag, "_no_done_at_accept"}, one ? done1 : done4, 0);
        lat = 0;
        while (lat < 40) begin
            tick;
            lat++;
            if (one ? done1 : done4) break;
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_out"}, one ? out1 : out4, exp_out);
        check({tag, "_bout"}, one ? bout1 : bout4, exp_bout);
        check({tag, "_busy_at_done"}, one ? busy1 : busy4, 0);
`ifdef SUB_OVERFLOW_EN
        check({tag, "_ovf"}, one ? ovf1 : ovf4, exp_ovf);
`endif
        tick;
        check({tag, "_done_one_cycle"}, one ? done1 : done4, 0);
        check({tag, "_out_held"}, one ? out1 : out4, exp_out);
    endtask

    initial begin
        int n_done;
        int first_at;
        tick;
        tick;
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_out", out4, 0);
        check("rst_bout", bout4, 0);
        check("rst_ovf", ovf4, 0);
        check("rst_out_w1", out1, 0);
        rst = 1'b1;

        op("basic", 0, 16'd1117, 16'd232, 1'b0, 4, 16'd885, 1'b0, 1'b0);
        op("borrow", 0, 16'd6452, 16'd55123, 1'b1, 4, 16'd16864, 1'b1, 1'b0);
        op("sovf", 0, 16'd32768, 16'd1, 1'b0, 4, 16'd32767, 1'b0, 1'b1);
        op("zero_minus_one", 0, 16'd0, 16'd1, 1'b0, 4, 16'd65535, 1'b1, 1'b0);

        in1 = 16'd1000; in2 = 16'd1; bin = 1'b0; start4 = 1'b1;
        n_done = 0; first_at = -1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (i == 0) begin in1 = 16'd5; in2 = 16'd9; end
            if (i == 9) start4 = 1'b0;
            if (done4) begin
                n_done++;
                if (n_done == 1) begin
                    first_at = i;
                    check("held_first_out", out4, 999);
                    check("held_first_bout", bout4, 0);
                end
                if (n_done == 2) begin
                    check("held_second_out", out4, 65532);
                    check("held_second_bout", bout4, 1);
                end
            end
        end
        check("held_first_latency", first_at, 4);
        check("held_done_count", n_done, 2);

        in1 = 16'd700; in2 = 16'd100; start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tick;
        rst = 1'b0;
        #1;
        check("abort_busy", busy4, 0);
        check("abort_done", done4, 0);
        check("abort_out", out4, 0);
        check("abort_bout", bout4, 0);
        check("abort_ovf", ovf4, 0);
        tick;
        tick;
        rst = 1'b1;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done4) n_done++;
        end
        check("abort_no_done", n_done, 0);
        op("after_abort", 0, 16'd500, 16'd200, 1'b0, 4, 16'd300, 1'b0, 1'b0);

        op("w1_all_ones", 1, 16'd65535, 16'd65535, 1'b1, 16, 16'd65535, 1'b1, 1'b0);
        op("w1_basic", 1, 16'd1117, 16'd232, 1'b0, 16, 16'd885, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
